// File: rtl/ctrl_input_conditioner.sv
// rtl/ctrl_input_conditioner.sv - per-channel polarity, sync, tick debounce, press/release strobes, auto-repeat
module ctrl_input_conditioner #(
  parameter int                  CHANNELS        = 4,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0,
  parameter int                  DEBOUNCE_TICKS  = 3,
  parameter int                  REPEAT_DELAY    = 30,
  parameter int                  REPEAT_RATE     = 6,
  parameter logic [CHANNELS-1:0] REPEAT_MASK     = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] level_n,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] repeat_p,
  output logic [CHANNELS-1:0] action
);

  localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } phase_e;

  logic [CHANNELS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pressed_q, pressed_d;
  logic [CHANNELS-1:0] released_q, released_d;
  logic [CHANNELS-1:0] repeat_q, repeat_d;
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [RW-1:0]       rcnt_q  [CHANNELS];
  logic [RW-1:0]       rcnt_d  [CHANNELS];
  phase_e              phase_q [CHANNELS];
  phase_e              phase_d [CHANNELS];
  logic [CHANNELS-1:0] norm;

  assign norm = s2_q ^ ACTIVE_LOW_MASK;

  always_comb begin
    s1_d       = raw_in;
    s2_d       = s1_q;
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    repeat_d   = '0;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    phase_d    = phase_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick) begin
        if (norm[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DB_LAST) begin
          level_d[i]    = norm[i];
          cnt_d[i]      = '0;
          pressed_d[i]  = norm[i];
          released_d[i] = ~norm[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // Repeat only runs while held both before and after this cycle, so the
      // press-commit and release-commit ticks both restart the delay phase.
      if (!REPEAT_MASK[i] || !(level_q[i] && level_d[i])) begin
        rcnt_d[i]  = '0;
        phase_d[i] = PH_DELAY;
      end else if (tick) begin
        if (phase_q[i] == PH_DELAY && rcnt_q[i] == RD_LAST) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = '0;
          phase_d[i]  = PH_RATE;
        end else if (phase_q[i] == PH_RATE && rcnt_q[i] == RR_LAST) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = '0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= ACTIVE_LOW_MASK;
      s2_q       <= ACTIVE_LOW_MASK;
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      repeat_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
        phase_q[i] <= PH_DELAY;
      end
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      repeat_q   <= repeat_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      phase_q    <= phase_d;
    end
  end

  assign level    = level_q;
  assign level_n  = ~level_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign repeat_p = repeat_q;
  assign action   = pressed_q | repeat_q;

endmodule

// File: tb/tb_ctrl_input_conditioner.sv
// tb/tb_ctrl_input_conditioner.sv - directed bench for ctrl_input_conditioner
module tb_ctrl_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] raw_a, raw_b;
  logic [3:0] a_level, a_level_n, a_pressed, a_released, a_repeat, a_action;
  logic [3:0] b_level, b_level_n, b_pressed, b_released, b_repeat, b_action;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ctrl_input_conditioner #(
    .CHANNELS(4), .ACTIVE_LOW_MASK(4'b0001), .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY(30), .REPEAT_RATE(6), .REPEAT_MASK(4'b1111)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw_in(raw_a),
    .level(a_level), .level_n(a_level_n), .pressed(a_pressed),
    .released(a_released), .repeat_p(a_repeat), .action(a_action)
  );

  ctrl_input_conditioner #(
    .CHANNELS(4), .ACTIVE_LOW_MASK(4'b0000), .DEBOUNCE_TICKS(1),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .REPEAT_MASK(4'b1111)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw_in(raw_b),
    .level(b_level), .level_n(b_level_n), .pressed(b_pressed),
    .released(b_released), .repeat_p(b_repeat), .action(b_action)
  );

  task automatic chk_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic chk_a(input string tag, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel);
    chk_eq({tag, "_level"}, a_level, lvl);
    chk_eq({tag, "_level_n"}, a_level_n, ~lvl);
    chk_eq({tag, "_pressed"}, a_pressed, prs);
    chk_eq({tag, "_released"}, a_released, rel);
  endtask

  initial begin
    logic [3:0] acc;
    int         n_act;
    rst_n = 1'b0;
    tick  = 1'b0;
    raw_a = 4'b0001;
    raw_b = 4'b0000;

    // Reset with toggling pins and ticks
    for (int i = 0; i < 4; i++) begin
      raw_a = 4'(i * 5);
      raw_b = ~raw_a;
      cyc(1'b1);
    end
    chk_a("rst_a", 4'b0000, 4'b0000, 4'b0000);
    chk_eq("rst_a_repeat", a_repeat, 4'b0000);
    chk_eq("rst_a_action", a_action, 4'b0000);
    chk_eq("rst_b_level", b_level, 4'b0000);
    chk_eq("rst_b_level_n", b_level_n, 4'b1111);
    chk_eq("rst_b_strobes", b_pressed | b_released | b_repeat | b_action, 4'b0000);

    raw_a = 4'b0001;
    raw_b = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      chk_eq("post_rst_a", a_pressed | a_released | a_repeat | a_level, 4'b0000);
      chk_eq("post_rst_b", b_pressed | b_released | b_repeat | b_level, 4'b0000);
    end

    // Active-low press on channel 0
    raw_a = 4'b0000;
    idle(3);
    cyc(1'b1); chk_a("press_t1", 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("press_t2", 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("press_t3", 4'b0001, 4'b0001, 4'b0000);
    cyc(1'b0); chk_a("press_after", 4'b0001, 4'b0000, 4'b0000);
    raw_a = 4'b0001;
    idle(3);
    cyc(1'b1); cyc(1'b1); chk_a("rel_t2", 4'b0001, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("rel_t3", 4'b0000, 4'b0000, 4'b0001);
    cyc(1'b0); chk_a("rel_after", 4'b0000, 4'b0000, 4'b0000);

    // Glitch on channel 2, then a full hold
    raw_a = 4'b0101;
    idle(3);
    cyc(1'b1); cyc(1'b1);
    raw_a = 4'b0001;
    idle(3);
    cyc(1'b1); chk_a("glitch", 4'b0000, 4'b0000, 4'b0000);
    raw_a = 4'b0101;
    idle(3);
    cyc(1'b1); cyc(1'b1); chk_a("restart_t2", 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("restart_t3", 4'b0100, 4'b0100, 4'b0000);
    raw_a = 4'b0001;
    idle(3);
    cyc(1'b1); cyc(1'b1); cyc(1'b1); chk_a("restart_rel", 4'b0000, 4'b0000, 4'b0100);

    // Reset landing on a commit tick for channels 1 and 2
    raw_a = 4'b0111;
    idle(3);
    cyc(1'b1); cyc(1'b1);
    rst_n = 1'b0;
    cyc(1'b1); chk_a("rst_commit", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    cyc(1'b0); chk_a("rst_commit_after", 4'b0000, 4'b0000, 4'b0000);
    idle(1);
    cyc(1'b1); cyc(1'b1); chk_a("rst_discard", 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("simul_press", 4'b0110, 4'b0110, 4'b0000);
    raw_a = 4'b0001;
    idle(3);
    cyc(1'b1); cyc(1'b1); cyc(1'b1); chk_a("simul_rel", 4'b0000, 4'b0000, 4'b0110);

    // Counters frozen while tick is low
    raw_a = 4'b1001;
    idle(3);
    cyc(1'b1);
    acc = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0);
      acc = acc | a_pressed | a_released | a_level;
    end
    chk_eq("gate_quiet", acc, 4'b0000);
    cyc(1'b1); chk_a("gate_t2", 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1); chk_a("gate_t3", 4'b1000, 4'b1000, 4'b0000);

    // Auto-repeat on channel 3 of the fast instance
    raw_b = 4'b1000;
    idle(3);
    n_act = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1);
      chk_eq($sformatf("rep_pressed_t%0d", k), b_pressed, (k == 1) ? 4'b1000 : 4'b0000);
      chk_eq($sformatf("rep_repeat_t%0d", k), b_repeat,
             (k == 5 || k == 7 || k == 9 || k == 11) ? 4'b1000 : 4'b0000);
      chk_eq($sformatf("rep_level_t%0d", k), b_level, 4'b1000);
      if (b_action[3]) n_act++;
      cyc(1'b0);
      chk_eq($sformatf("rep_gap_t%0d", k), b_action, 4'b0000);
    end
    chk_eq("rep_action_count", 4'(n_act), 4'd5);
    raw_b = 4'b0000;
    idle(3);
    chk_eq("rep_idle_level", b_level, 4'b1000);
    cyc(1'b1);
    chk_eq("rep_rel_released", b_released, 4'b1000);
    chk_eq("rep_rel_repeat", b_repeat, 4'b0000);
    chk_eq("rep_rel_level", b_level, 4'b0000);
    acc = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      acc = acc | b_repeat | b_action;
    end
    chk_eq("rep_after_rel", acc, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
